// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the three handshake ports of the shared memory arbiter:
//   IFU fetch port, LSU load/store port and the downstream memory port.
//
//   modport master : the arbiter itself, which owns the shared memory port
//                    (takes IFU/LSU requests, drives the memory request).
//   modport slave  : the attached agents (IFU, LSU, memory), i.e. everything
//                    on the far side of the arbiter.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MASK_WIDTH = 8
);
  // IFU (read-only fetch)
  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [ADDR_WIDTH-1:0] ifu_addr;
  logic                  ifu_resp_valid;
  logic                  ifu_resp_ready;
  logic [DATA_WIDTH-1:0] ifu_rdata;

  // LSU (load/store)
  logic                  lsu_req_valid;
  logic                  lsu_req_ready;
  logic [ADDR_WIDTH-1:0] lsu_addr;
  logic                  lsu_wen;
  logic [DATA_WIDTH-1:0] lsu_wdata;
  logic [MASK_WIDTH-1:0] lsu_wmask;
  logic                  lsu_resp_valid;
  logic                  lsu_resp_ready;
  logic [DATA_WIDTH-1:0] lsu_rdata;

  // Memory slave
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_wen;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [MASK_WIDTH-1:0] mem_wmask;
  logic                  mem_resp_valid;
  logic                  mem_resp_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    input  ifu_req_valid, ifu_addr, ifu_resp_ready,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_resp_ready,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport slave (
    output ifu_req_valid, ifu_addr, ifu_resp_ready,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_resp_ready,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single instruction/data memory port between the IFU (fetch)
//   and the LSU (load/store). One transaction at a time:
//   IDLE (grant) -> REQ (issue to memory) -> RESP (route response) -> IDLE.
//   Default policy: fixed priority, LSU wins a tie (older instruction).
//
//   Optional build macro MEM_ARB_RR_EN: ties alternate using a last_grant
//   flop (reset to LSU, so the first tie after reset goes to the IFU).
//
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset
//   bus   - mem_arbiter_if.master: IFU, LSU and memory handshakes
//   busy  - state != IDLE
//   owner - current/last grant, 0 = IFU, 1 = LSU
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MASK_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                state_q,         state_d;
  logic                  owner_q,         owner_d;
  logic [ADDR_WIDTH-1:0] addr_q,          addr_d;
  logic                  wen_q,           wen_d;
  logic [DATA_WIDTH-1:0] wdata_q,         wdata_d;
  logic [MASK_WIDTH-1:0] wmask_q,         wmask_d;
  logic                  mem_req_valid_q, mem_req_valid_d;
  logic                  busy_q,          busy_d;
`ifdef MEM_ARB_RR_EN
  logic                  last_grant_q,    last_grant_d;
`endif

  logic lsu_win;
  logic ifu_win;
  logic in_idle;
  logic in_resp;
  logic resp_rdy;

  // Grant selection (only meaningful in IDLE).
  always_comb begin
`ifdef MEM_ARB_RR_EN
    // On a tie, grant whichever master did not win last time.
    lsu_win = bus.lsu_req_valid && (!bus.ifu_req_valid || !last_grant_q);
`else
    lsu_win = bus.lsu_req_valid;
`endif
    ifu_win = bus.ifu_req_valid && !lsu_win;
  end

  // Combinational paths are gated by rst so nothing is presented to the
  // masters while reset is held, even if the state register is mid-flight.
  assign in_idle  = (state_q == IDLE) && !rst;
  assign in_resp  = (state_q == RESP) && !rst;
  assign resp_rdy = in_resp && (owner_q ? bus.lsu_resp_ready : bus.ifu_resp_ready);

  // Next-state logic.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    addr_d          = addr_q;
    wen_d           = wen_q;
    wdata_d         = wdata_q;
    wmask_d         = wmask_q;
    mem_req_valid_d = mem_req_valid_q;
    busy_d          = busy_q;
`ifdef MEM_ARB_RR_EN
    last_grant_d    = last_grant_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (lsu_win) begin
          state_d         = REQ;
          owner_d         = 1'b1;
          addr_d          = bus.lsu_addr;
          wen_d           = bus.lsu_wen;
          wdata_d         = bus.lsu_wdata;
          wmask_d         = bus.lsu_wmask;
          mem_req_valid_d = 1'b1;
          busy_d          = 1'b1;
`ifdef MEM_ARB_RR_EN
          last_grant_d    = 1'b1;
`endif
        end else if (ifu_win) begin
          state_d         = REQ;
          owner_d         = 1'b0;
          addr_d          = bus.ifu_addr;
          wen_d           = 1'b0;
          wdata_d         = '0;
          wmask_d         = '0;
          mem_req_valid_d = 1'b1;
          busy_d          = 1'b1;
`ifdef MEM_ARB_RR_EN
          last_grant_d    = 1'b0;
`endif
        end
      end
      REQ: begin
        if (bus.mem_req_ready) begin
          state_d         = RESP;
          mem_req_valid_d = 1'b0;
        end
      end
      RESP: begin
        if (bus.mem_resp_valid && resp_rdy) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d         = IDLE;
        mem_req_valid_d = 1'b0;
        busy_d          = 1'b0;
      end
    endcase
  end

  // State register; mem_req_valid and busy are kept as registered flags
  // alongside the state so they come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      owner_q         <= 1'b0;
      addr_q          <= '0;
      wen_q           <= 1'b0;
      wdata_q         <= '0;
      wmask_q         <= '0;
      mem_req_valid_q <= 1'b0;
      busy_q          <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant_q    <= 1'b1;
`endif
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      addr_q          <= addr_d;
      wen_q           <= wen_d;
      wdata_q         <= wdata_d;
      wmask_q         <= wmask_d;
      mem_req_valid_q <= mem_req_valid_d;
      busy_q          <= busy_d;
`ifdef MEM_ARB_RR_EN
      last_grant_q    <= last_grant_d;
`endif
    end
  end

  // Master request side.
  assign bus.lsu_req_ready  = in_idle && lsu_win;
  assign bus.ifu_req_ready  = in_idle && ifu_win;

  // Memory request side, payload held in the latched registers.
  assign bus.mem_req_valid  = mem_req_valid_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wen        = wen_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wmask      = wmask_q;

  // Response routing: only the owner sees mem_resp_valid.
  assign bus.mem_resp_ready = resp_rdy;
  assign bus.ifu_resp_valid = in_resp && !owner_q && bus.mem_resp_valid;
  assign bus.lsu_resp_valid = in_resp &&  owner_q && bus.mem_resp_valid;
  assign bus.ifu_rdata      = bus.mem_rdata;
  assign bus.lsu_rdata      = bus.mem_rdata;

  assign busy  = busy_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed self-checking bench for mem_arbiter. Inputs are driven on the
//   falling edge and outputs sampled 1 time unit later, away from the
//   rising (active) edge. Expected values are hand-computed constants.
module tb_mem_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 8;

`ifdef MEM_ARB_RR_EN
  localparam bit FIRST_LSU = 1'b0;
`else
  localparam bit FIRST_LSU = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic owner;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .busy  (busy),
    .owner (owner)
  );

  int passed = 0;
  int total  = 0;

  task automatic clear_inputs();
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_addr       = '0;
    bus.ifu_resp_ready = 1'b0;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_addr       = '0;
    bus.lsu_wen        = 1'b0;
    bus.lsu_wdata      = '0;
    bus.lsu_wmask      = '0;
    bus.lsu_resp_ready = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
  endtask

  task automatic test_reset();
    logic [7:0]  flags;
    logic [72:0] pay;
    clear_inputs();
    rst = 1'b1;
    bus.ifu_req_valid  = 1'b1;
    bus.lsu_req_valid  = 1'b1;
    bus.mem_resp_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    flags = {bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_resp_valid, bus.lsu_resp_valid,
             bus.mem_req_valid, bus.mem_resp_ready, busy, owner};
    total++;
    if (flags !== 8'h00) $display("FAIL reset_outputs: got %b expected %b", flags, 8'h00);
    else passed++;
    pay = {bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask};
    total++;
    if (pay !== 73'h0) $display("FAIL reset_payload: got %h expected 0", pay);
    else passed++;
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    #1;
    flags = {bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_resp_valid, bus.lsu_resp_valid,
             bus.mem_req_valid, bus.mem_resp_ready, busy, owner};
    total++;
    if (flags !== 8'h00) $display("FAIL idle_after_reset: got %b expected %b", flags, 8'h00);
    else passed++;
  endtask

  task automatic test_ifu_alone();
    logic [4:0] v;
    // cycle 0: request
    @(negedge clk);
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0000;
    #1;
    total++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b10)
      $display("FAIL ifu_grant: got %b expected 10", {bus.ifu_req_ready, bus.lsu_req_ready});
    else passed++;
    // cycle 1: memory request
    @(negedge clk);
    bus.ifu_req_valid  = 1'b0;
    bus.mem_req_ready  = 1'b1;
    bus.ifu_resp_ready = 1'b1;
    #1;
    v = {bus.mem_req_valid, bus.mem_wen, busy, owner, bus.ifu_req_ready};
    total++;
    if (v !== 5'b10100) $display("FAIL ifu_mem_req: got %b expected 10100", v);
    else passed++;
    total++;
    if (bus.mem_addr !== 32'h8000_0000)
      $display("FAIL ifu_mem_addr: got %h expected 80000000", bus.mem_addr);
    else passed++;
    // cycle 2: response
    @(negedge clk);
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h0000_0413;
    #1;
    total++;
    if ({bus.ifu_resp_valid, bus.lsu_resp_valid, bus.mem_resp_ready, bus.mem_req_valid} !== 4'b1010)
      $display("FAIL ifu_resp: got %b expected 1010",
               {bus.ifu_resp_valid, bus.lsu_resp_valid, bus.mem_resp_ready, bus.mem_req_valid});
    else passed++;
    total++;
    if (bus.ifu_rdata !== 32'h0000_0413)
      $display("FAIL ifu_rdata: got %h expected 00000413", bus.ifu_rdata);
    else passed++;
    // cycle 3: back to idle
    @(negedge clk);
    clear_inputs();
    #1;
    total++;
    if ({busy, bus.ifu_resp_valid, bus.lsu_resp_valid} !== 3'b000)
      $display("FAIL ifu_done: got %b expected 000", {busy, bus.ifu_resp_valid, bus.lsu_resp_valid});
    else passed++;
  endtask

  task automatic test_lsu_store();
    @(negedge clk);
    bus.lsu_req_valid = 1'b1;
    bus.lsu_wen       = 1'b1;
    bus.lsu_addr      = 32'h8000_1000;
    bus.lsu_wdata     = 32'hDEAD_BEEF;
    bus.lsu_wmask     = 8'h0F;
    #1;
    total++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b01)
      $display("FAIL lsu_grant: got %b expected 01", {bus.ifu_req_ready, bus.lsu_req_ready});
    else passed++;
    @(negedge clk);
    // scramble the master payload: the memory side must use the latched copy
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_wen        = 1'b0;
    bus.lsu_addr       = '0;
    bus.lsu_wdata      = '0;
    bus.lsu_wmask      = '0;
    bus.mem_req_ready  = 1'b1;
    bus.lsu_resp_ready = 1'b1;
    #1;
    total++;
    if ({bus.mem_req_valid, bus.mem_wen, busy, owner} !== 4'b1111)
      $display("FAIL store_mem_ctrl: got %b expected 1111", {bus.mem_req_valid, bus.mem_wen, busy, owner});
    else passed++;
    total++;
    if ({bus.mem_addr, bus.mem_wdata, bus.mem_wmask} !== {32'h8000_1000, 32'hDEAD_BEEF, 8'h0F})
      $display("FAIL store_mem_payload: got %h %h %h expected 80001000 deadbeef 0f",
               bus.mem_addr, bus.mem_wdata, bus.mem_wmask);
    else passed++;
    @(negedge clk);
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    #1;
    total++;
    if ({bus.lsu_resp_valid, bus.ifu_resp_valid, bus.mem_resp_ready} !== 3'b101)
      $display("FAIL store_ack: got %b expected 101", {bus.lsu_resp_valid, bus.ifu_resp_valid, bus.mem_resp_ready});
    else passed++;
    // a stale mem_resp_valid after the ack must not produce a second pulse
    @(negedge clk);
    #1;
    total++;
    if ({busy, bus.lsu_resp_valid, bus.mem_resp_ready} !== 3'b000)
      $display("FAIL store_ack_once: got %b expected 000", {busy, bus.lsu_resp_valid, bus.mem_resp_ready});
    else passed++;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_tie();
    logic [31:0] a_ifu;
    logic [31:0] a_lsu;
    logic [31:0] a_first;
    logic [31:0] a_second;
    a_ifu    = 32'h8000_0100;
    a_lsu    = 32'h8000_3000;
    a_first  = FIRST_LSU ? a_lsu : a_ifu;
    a_second = FIRST_LSU ? a_ifu : a_lsu;
    // cycle 0: both request
    @(negedge clk);
    bus.ifu_req_valid  = 1'b1;
    bus.ifu_addr       = a_ifu;
    bus.lsu_req_valid  = 1'b1;
    bus.lsu_addr       = a_lsu;
    bus.ifu_resp_ready = 1'b1;
    bus.lsu_resp_ready = 1'b1;
    #1;
    total++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready} !== {!FIRST_LSU, FIRST_LSU})
      $display("FAIL tie_first_grant: got %b expected %b",
               {bus.ifu_req_ready, bus.lsu_req_ready}, {!FIRST_LSU, FIRST_LSU});
    else passed++;
    // cycle 1: winner drops, loser holds; request phase ignores the loser
    @(negedge clk);
    if (FIRST_LSU) bus.lsu_req_valid = 1'b0;
    else           bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    #1;
    total++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready, owner, bus.mem_req_valid, bus.mem_addr} !==
        {2'b00, FIRST_LSU, 1'b1, a_first})
      $display("FAIL tie_first_req: got %b%b%b%b %h expected 00%b1 %h",
               bus.ifu_req_ready, bus.lsu_req_ready, owner, bus.mem_req_valid, bus.mem_addr,
               FIRST_LSU, a_first);
    else passed++;
    // cycle 2: first response
    @(negedge clk);
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h0000_000A;
    #1;
    total++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_resp_valid, bus.lsu_resp_valid} !==
        {2'b00, !FIRST_LSU, FIRST_LSU})
      $display("FAIL tie_first_resp: got %b expected 00%b%b",
               {bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_resp_valid, bus.lsu_resp_valid},
               !FIRST_LSU, FIRST_LSU);
    else passed++;
    // cycle 3: next IDLE grants the loser (N+3)
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    #1;
    total++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready} !== {FIRST_LSU, !FIRST_LSU})
      $display("FAIL tie_second_grant: got %b expected %b",
               {bus.ifu_req_ready, bus.lsu_req_ready}, {FIRST_LSU, !FIRST_LSU});
    else passed++;
    // cycle 4
    @(negedge clk);
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    #1;
    total++;
    if ({owner, bus.mem_req_valid, bus.mem_addr} !== {!FIRST_LSU, 1'b1, a_second})
      $display("FAIL tie_second_req: got %b%b %h expected %b1 %h",
               owner, bus.mem_req_valid, bus.mem_addr, !FIRST_LSU, a_second);
    else passed++;
    // cycle 5
    @(negedge clk);
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    #1;
    total++;
    if ({bus.ifu_resp_valid, bus.lsu_resp_valid} !== {FIRST_LSU, !FIRST_LSU})
      $display("FAIL tie_second_resp: got %b expected %b",
               {bus.ifu_resp_valid, bus.lsu_resp_valid}, {FIRST_LSU, !FIRST_LSU});
    else passed++;
    // cycle 6
    @(negedge clk);
    clear_inputs();
    #1;
    total++;
    if (busy !== 1'b0) $display("FAIL tie_done: got busy=%b expected 0", busy);
    else passed++;
  endtask

  task automatic test_stall();
    int   acks;
    logic [72:0] pay;
    acks = 0;
    @(negedge clk);
    bus.lsu_req_valid = 1'b1;
    bus.lsu_wen       = 1'b1;
    bus.lsu_addr      = 32'h8000_2000;
    bus.lsu_wdata     = 32'h1234_5678;
    bus.lsu_wmask     = 8'hA5;
    #1;
    total++;
    if (bus.lsu_req_ready !== 1'b1) $display("FAIL stall_grant: got %b expected 1", bus.lsu_req_ready);
    else passed++;
    // memory not ready for three cycles, then accepts on the fourth
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.lsu_req_valid = 1'b0;
      bus.lsu_addr      = 32'h0BAD_0000 + 32'(i);
      bus.lsu_wdata     = 32'hFFFF_0000 + 32'(i);
      bus.mem_req_ready = (i == 3);
      #1;
      pay = {bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask};
      total++;
      if (!bus.mem_req_valid || pay !== {32'h8000_2000, 1'b1, 32'h1234_5678, 8'hA5})
        $display("FAIL stall_req_hold[%0d]: got valid=%b %h expected valid=1 %h",
                 i, bus.mem_req_valid, pay, {32'h8000_2000, 1'b1, 32'h1234_5678, 8'hA5});
      else passed++;
    end
    // response valid, owner not ready for two cycles, then ready
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = 32'h0000_0055;
      bus.lsu_resp_ready = (i == 2);
      #1;
      if (bus.lsu_resp_valid && bus.lsu_resp_ready) acks++;
      total++;
      if ({bus.mem_resp_ready, bus.lsu_resp_valid, busy} !== {(i == 2), 2'b11})
        $display("FAIL stall_resp[%0d]: got %b expected %b%b",
                 i, {bus.mem_resp_ready, bus.lsu_resp_valid, busy}, (i == 2), 2'b11);
      else passed++;
    end
    // stale valid after completion
    @(negedge clk);
    #1;
    if (bus.lsu_resp_valid && bus.lsu_resp_ready) acks++;
    total++;
    if ({busy, bus.lsu_resp_valid} !== 2'b00)
      $display("FAIL stall_after: got %b expected 00", {busy, bus.lsu_resp_valid});
    else passed++;
    total++;
    if (acks !== 1) $display("FAIL stall_single_resp: got %0d responses expected 1", acks);
    else passed++;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    logic [7:0] flags;
    @(negedge clk);
    bus.lsu_req_valid = 1'b1;
    bus.lsu_wen       = 1'b0;
    bus.lsu_addr      = 32'h8000_4000;
    @(negedge clk);
    bus.lsu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    #1;
    total++;
    if ({busy, owner} !== 2'b11) $display("FAIL rmid_in_resp: got %b expected 11", {busy, owner});
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    #1;
    flags = {bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_resp_valid, bus.lsu_resp_valid,
             bus.mem_req_valid, bus.mem_resp_ready, busy, owner};
    total++;
    if (flags !== 8'h00) $display("FAIL rmid_after_reset: got %b expected 00000000", flags);
    else passed++;
    rst = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.ifu_resp_ready = 1'b1;
    bus.lsu_resp_ready = 1'b1;
    #1;
    flags = {bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_resp_valid, bus.lsu_resp_valid,
             bus.mem_req_valid, bus.mem_resp_ready, busy, owner};
    total++;
    if (flags !== 8'h00) $display("FAIL rmid_late_resp: got %b expected 00000000", flags);
    else passed++;
    @(negedge clk);
    #1;
    flags = {bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_resp_valid, bus.lsu_resp_valid,
             bus.mem_req_valid, bus.mem_resp_ready, busy, owner};
    total++;
    if (flags !== 8'h00) $display("FAIL rmid_late_resp2: got %b expected 00000000", flags);
    else passed++;
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_ifu_alone();
    test_lsu_store();
    test_tie();
    test_stall();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
